piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in serial-out stage that sits directly upstream of the left shift register and drives its serial d input.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts each word out MSB first, one bit per clock.
- Inserts an optional idle gap between words.
- Flags the cycle in which the downstream left shift register holds the complete word. With WIDTH=4, the downstream 4-bit out then equals the accepted word.

Parameters:
WIDTH, 4, word width and bits per frame (>=2)
GAP, 0, idle cycles inserted after each word (0 = back-to-back)
IDLE_LEVEL, 0, value driven on serial_out when not shifting

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  WIDTH  parallel word to serialize
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
serial_out  output  1  serial bit stream, MSB first; connects to downstream d
last_bit  output  1  high while serial_out carries bit 0 of the current word
word_done  output  1  one-cycle pulse, the cycle after last_bit; downstream register holds the full word
busy  output  1  state != IDLE
word_count  output  8  count of completed words, wraps 255 -> 0

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=IDLE, shift reg=0, bit_cnt=0, gap_cnt=0;
  - serial_out=IDLE_LEVEL, last_bit=0, word_done=0, busy=0, word_count=0;
  - in_ready=0, and all inputs are ignored.
- After rst deasserts: IDLE with in_ready=1.
- Handshake:
  - A word is accepted on a rising edge where in_valid=1 and in_ready=1.
  - The source holds in_data stable while in_valid=1 and in_ready=0.
  - in_valid=1 with in_ready=0 consumes nothing.
- State IDLE:
  - serial_out=IDLE_LEVEL, in_ready=1.
  - On accept: load shift reg with in_data, bit_cnt=0, go SHIFT.
- State SHIFT:
  - serial_out = shift reg MSB, driven from a register with no combinational path from inputs.
  - Each edge shifts the register left by one and increments bit_cnt.
  - last_bit = (bit_cnt == WIDTH-1).
  - Latency: the first bit appears on serial_out in the cycle after the accepting edge.
  - Each word occupies exactly WIDTH cycles.
- End of word (edge with last_bit=1):
  - GAP>0: go GAP, gap_cnt=0.
  - GAP=0 and in_valid=1: accept the next word in the same edge and stay in SHIFT with bit_cnt=0. There is no bubble.
  - GAP=0 and in_valid=0: go IDLE.
- in_ready = (state==IDLE) OR (last_bit AND GAP==0), forced to 0 during reset.
- State GAP:
  - serial_out=IDLE_LEVEL, in_ready=0.
  - Lasts exactly GAP cycles, then goes IDLE. The earliest next accept is at the edge ending the first IDLE cycle.
- word_done:
  - Registered copy of last_bit, high for exactly one cycle per word.
  - In that cycle the downstream left shift register's low WIDTH bits equal the word.
  - Back-to-back words: word_done coincides with bit MSB of the next word.
- word_count:
  - Increments on the edge where word_done is set, i.e. together with the word_done rise.
  - 8-bit wrap, no saturation.
- Reset mid-word:
  - Aborts immediately (asynchronously); the partial word is discarded.
  - No word_done is produced and word_count is cleared.
- Idle serial_out: IDLE_LEVEL=0 keeps the downstream register filling with zeros between words.

Test Plan:
1. WIDTH=4, GAP=0: reset, then accept 4'b1011 -> serial_out 1,0,1,1 on four consecutive cycles; last_bit high on the 4th; word_done high on the next cycle, with downstream out=4'hB; word_count=1; then IDLE, serial_out=0.
2. Back-to-back, GAP=0, in_valid held with 4'hB then 4'h6 -> in_ready=1 during the last bit of B; 8 contiguous bits 1,0,1,1,0,1,1,0; word_done pulses twice, 4 cycles apart; downstream out=4'hB then 4'h6; word_count=2.
3. GAP=2, two words 4'hF and 4'h9 offered continuously -> after the 4 bits of F, two cycles of serial_out=0 with in_ready=0 and busy=1; then one IDLE cycle with in_ready=1; bits of 9 (1,0,0,1) follow.
4. Reset mid-word: accept 4'hA, assert rst after 2 bits -> serial_out=0, busy=0, in_ready=0 immediately; no word_done; word_count=0; after release, accepting 4'h5 works normally.
5. Backpressure: assert in_valid with 4'hC during SHIFT of a prior word (GAP=0) -> C is not accepted before the last_bit cycle; it is serialized exactly once.
6. Wrap: 256 consecutive random words (seed=1) -> word_count returns to 0; every word_done cycle shows downstream out equal to the corresponding sent word.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage feeding a downstream left shift register (MSB first).
// Latency: first bit on serial_out the cycle after accept; each word takes WIDTH cycles, then GAP idle cycles.
// Backpressure: in_ready is high in IDLE, or on the last bit when GAP==0, so back-to-back words leave no bubble.
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter int GAP        = 0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             last_bit,
  output logic             word_done,
  output logic             busy,
  output logic [7:0]       word_count
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_word_done;
  logic [7:0]       r_word_count;

  logic w_last_bit;
  logic w_accept;

  // Last bit of the word is on the wire when the counter reaches WIDTH-1.
  assign w_last_bit = (r_state == S_SHIFT) && (r_bit_cnt == BW'(WIDTH - 1));
  assign w_accept   = in_valid && in_ready;

  // Ready only from state registers (and reset), never from in_valid.
  assign in_ready   = ~rst & ((r_state == S_IDLE) | (w_last_bit & (GAP == 0)));

  // Serial line comes straight from the shift register MSB while shifting.
  assign serial_out = (r_state == S_SHIFT) ? r_shift[WIDTH-1] : IDLE_LEVEL;
  assign last_bit   = w_last_bit;
  assign word_done  = r_word_done;
  assign busy       = (r_state != S_IDLE);
  assign word_count = r_word_count;

  // Main FSM: load, shift, optional idle gap; completion pulse and word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_word_done  <= 1'b0;
      r_word_count <= 8'd0;
    end else begin
      // Downstream holds the full word one edge after its last bit was driven.
      r_word_done <= w_last_bit;
      if (w_last_bit) begin
        r_word_count <= r_word_count + 8'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift   <= in_data;
            r_bit_cnt <= '0;
            r_state   <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + BW'(1);
          if (w_last_bit) begin
            r_bit_cnt <= '0;
            if (GAP > 0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= '0;
            end else if (in_valid) begin
              // Chained word: reload in the same edge, stay in SHIFT.
              r_shift <= in_data;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        S_GAP: begin
          if (int'(r_gap_cnt) >= GAP - 1) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: one GAP=0 instance and one GAP=2 instance, each driving a model
// of the downstream 4-bit left shift register; a per-cycle reference model predicts every output.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [3:0] dat  [2];
  logic       vld  [2];
  logic       rdy  [2];
  logic       ser  [2];
  logic       lastb[2];
  logic       done [2];
  logic       bsy  [2];
  logic [7:0] wcnt [2];
  logic [3:0] ds   [2];

  int nerr = 0;
  int nchk = 0;

  // Reference model state (per instance)
  bit         bitq   [2][$];
  bit         lastq  [2][$];
  logic [3:0] wordq  [2][$];
  int         gap_left [2];
  bit         done_pend[2];
  logic [7:0] cnt      [2];

  piso_serializer #(.WIDTH(4), .GAP(0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_data(dat[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .serial_out(ser[0]), .last_bit(lastb[0]), .word_done(done[0]), .busy(bsy[0]),
    .word_count(wcnt[0])
  );

  piso_serializer #(.WIDTH(4), .GAP(2), .IDLE_LEVEL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_data(dat[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .serial_out(ser[1]), .last_bit(lastb[1]), .word_done(done[1]), .busy(bsy[1]),
    .word_count(wcnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream left shift registers fed by serial_out
  always @(posedge clk) begin
    ds[0] <= {ds[0][2:0], ser[0]};
    ds[1] <= {ds[1][2:0], ser[1]};
  end

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // Per-cycle model: each accepted word becomes 4 scheduled bits, then GAP idle cycles.
  task automatic mon(input int d);
    bit         eb, el, ebusy, erdy;
    logic [3:0] w;
    if (rst) begin
      chk("rst_serial", d, ser[d], 0);
      chk("rst_busy", d, bsy[d], 0);
      chk("rst_ready", d, rdy[d], 0);
      chk("rst_done", d, done[d], 0);
      chk("rst_count", d, wcnt[d], 0);
      bitq[d].delete(); lastq[d].delete(); wordq[d].delete();
      gap_left[d] = 0; done_pend[d] = 0; cnt[d] = 8'd0;
      return;
    end
    chk("word_done", d, done[d], done_pend[d]);
    if (done_pend[d]) begin
      w = wordq[d].pop_front();
      cnt[d] = cnt[d] + 8'd1;
      chk("downstream_out", d, ds[d], w);
      chk("word_count", d, wcnt[d], cnt[d]);
    end
    done_pend[d] = 0;
    if (bitq[d].size() > 0) begin
      eb = bitq[d].pop_front();
      el = lastq[d].pop_front();
      ebusy = 1;
      erdy = el && (gap_of(d) == 0);
      if (el) begin
        done_pend[d] = 1;
        gap_left[d]  = gap_of(d);
      end
    end else if (gap_left[d] > 0) begin
      eb = 0; el = 0; ebusy = 1; erdy = 0;
      gap_left[d]--;
    end else begin
      eb = 0; el = 0; ebusy = 0; erdy = 1;
    end
    chk("serial_out", d, ser[d], eb);
    chk("last_bit", d, lastb[d], el);
    chk("busy", d, bsy[d], ebusy);
    chk("in_ready", d, rdy[d], erdy);
    if (vld[d] && erdy) begin
      for (int i = 3; i >= 0; i--) begin
        bitq[d].push_back(dat[d][i]);
        lastq[d].push_back(i == 0);
      end
      wordq[d].push_back(dat[d]);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Offer a word and hold it until accepted (bounded wait).
  task automatic send(input int d, input logic [3:0] w);
    int n;
    n = 0;
    vld[d] = 1'b1;
    dat[d] = w;
    @(negedge clk);
    while (!rdy[d] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!rdy[d]) begin
      nchk++;
      nerr++;
      $display("FAIL accept_timeout dut%0d: in_ready stayed 0, word %0h not accepted", d, w);
    end
    @(posedge clk);
    #1;
    vld[d] = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int seed_dummy;
    seed_dummy = $urandom(1);
    rst = 1'b1;
    vld[0] = 1'b0; vld[1] = 1'b0;
    dat[0] = 4'h0; dat[1] = 4'h0;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);

    fork
      begin
        // Single word, then back-to-back pair, then a word waiting behind another
        send(0, 4'hB);
        wait_cycles(8);
        send(0, 4'hB);
        send(0, 4'h6);
        wait_cycles(8);
        send(0, 4'(($urandom)));
        send(0, 4'hC);
        wait_cycles(8);
      end
      begin
        // GAP=2 instance: two words offered continuously, then random traffic
        send(1, 4'hF);
        send(1, 4'h9);
        wait_cycles(10);
        for (int i = 0; i < 20; i++) begin
          send(1, 4'($urandom));
          wait_cycles($urandom_range(0, 2));
        end
        wait_cycles(8);
      end
    join

    // Reset in the middle of a word
    send(0, 4'hA);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);
    send(0, 4'h5);
    wait_cycles(8);

    // Counter wrap: fresh reset, then 256 consecutive words
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);
    for (int i = 0; i < 256; i++) begin
      send(0, 4'($urandom));
    end
    wait_cycles(8);
    chk("wrap_count", 0, wcnt[0], 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
